// File: rtl/bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bit_serializer_pkg
// Shared types and constants for the bit serializer.
//   state_t       : FSM state encoding (IDLE, START, SHIFT, DONE)
//   N_DEFAULT     : default word width
//   DIV_W_DEFAULT : default width of the bit-period divider
//   cnt_width()   : width of a counter that must hold the value n
// -----------------------------------------------------------------------------
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int N_DEFAULT     = 8;
    localparam int DIV_W_DEFAULT = 16;

    // The bit counter has to reach N itself (not just N-1), hence n+1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// -----------------------------------------------------------------------------
// bit_serializer_if
// Bundles the word handshake, control inputs and serial outputs of the
// bit serializer.
//   din, din_valid, din_ready : parallel word handshake
//   div                       : bit period minus one (clk cycles)
//   abort                     : synchronous frame abort
//   out, out_en               : serial bit and its one-cycle strobe
//   frame_start               : one-cycle pulse ahead of each frame
//   busy, done                : frame in progress / frame completed pulse
// Modports: master (word source / sink side), slave (serializer side).
// -----------------------------------------------------------------------------
interface bit_serializer_if
    import bit_serializer_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DIV_W = DIV_W_DEFAULT
);

    logic [N-1:0]     din;
    logic             din_valid;
    logic             din_ready;
    logic [DIV_W-1:0] div;
    logic             abort;
    logic             out;
    logic             out_en;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output din, din_valid, div, abort,
        input  din_ready, out, out_en, frame_start, busy, done
    );

    modport slave (
        input  din, din_valid, div, abort,
        output din_ready, out, out_en, frame_start, busy, done
    );

endinterface

// File: rtl/bit_serializer_period_counter.sv
// -----------------------------------------------------------------------------
// period_counter
// Bit-period down-counter. Loads a value, counts down one per enabled cycle
// and saturates at zero; zero_o flags the end of a bit period.
//   clk, reset  : clock, synchronous active-high reset (clears the count)
//   load_i      : load load_val_i (takes priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one; ignored when the count is already zero
//   zero_o      : count is zero (decoded from the register only)
// -----------------------------------------------------------------------------
module period_counter #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Accepts an N-bit word and shifts it out MSB first, one bit every div+1
// clk cycles, as a strobed serial stream for an LSB-in downstream shift
// register. frame_start clears the downstream register ahead of the frame,
// done pulses once after the last bit.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : bit_serializer_if.slave (din/din_valid/din_ready, div, abort,
//           out, out_en, frame_start, busy, done)
// Every output comes straight from a register; inputs only steer next state.
// -----------------------------------------------------------------------------
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    bit_serializer_if.slave   bus
);

    localparam int             CW    = cnt_width(N);
    localparam logic [CW-1:0]  N_CNT = CW'(N);

    state_t           state_q;
    logic [N-1:0]     word_q;
    logic [DIV_W-1:0] div_q;
    logic [CW-1:0]    bit_cnt_q;
    logic             out_q;
    logic             out_en_q;
    logic             frame_start_q;
    logic             done_q;
    logic             busy_q;
    logic             ready_q;

    logic             cnt_zero;
    logic             cnt_load;
    logic             cnt_dec;
    logic             last_bit_sent;

    assign last_bit_sent = (bit_cnt_q == N_CNT);

    // The counter is armed with the latched divider on leaving START and
    // re-armed on every strobe; it only counts while a bit is pending.
    assign cnt_load = !bus.abort &&
                      ((state_q == START) ||
                       ((state_q == SHIFT) && !last_bit_sent && cnt_zero));
    assign cnt_dec  = !bus.abort && (state_q == SHIFT) && !cnt_zero;

    period_counter #(
        .DIV_W (DIV_W)
    ) u_period_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (div_q),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            word_q        <= '0;
            div_q         <= '0;
            bit_cnt_q     <= '0;
            out_q         <= 1'b0;
            out_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            // Pulse outputs default low; out stays 0 between strobes.
            out_q         <= 1'b0;
            out_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;

            case (state_q)
                IDLE: begin
                    // abort is deliberately not looked at here.
                    if (bus.din_valid) begin
                        word_q        <= bus.din;
                        div_q         <= bus.div;
                        state_q       <= START;
                        frame_start_q <= 1'b1;
                        busy_q        <= 1'b1;
                        ready_q       <= 1'b0;
                    end
                end

                START: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                    end
                end

                SHIFT: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (last_bit_sent) begin
                        // One cycle after the N-th strobe, so done never
                        // overlaps the final out_en.
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (cnt_zero) begin
                        out_q     <= word_q[N-1];
                        out_en_q  <= 1'b1;
                        word_q    <= {word_q[N-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.din_ready   = ready_q;
    assign bus.out         = out_q;
    assign bus.out_en      = out_en_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
